// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int RF_DATA_W_DEFAULT = 32;
  localparam int RF_DEPTH_DEFAULT  = 32;

  // Address width for a given depth; never narrower than one bit.
  function automatic int rf_clog2(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_bypass_mux.sv
// Per-read-port write-first bypass: returns the value a register will hold after
// this edge's writes, with the highest-index write port winning.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W_DEFAULT,
  parameter int DEPTH   = RF_DEPTH_DEFAULT,
  parameter int NUM_WR  = 1,
  parameter int ZERO_R0 = 1,
  parameter int ADDR_W  = rf_clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        value
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic in_range;
  logic is_zero_reg;

  assign in_range    = ({1'b0, rd_addr} < DEPTH_LIM);
  assign is_zero_reg = (ZERO_R0 != 0) && (rd_addr == '0);

  // Later ports overwrite earlier matches, giving highest-index-wins priority.
  always_comb begin
    value = arr_data;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr)) begin
        value = wr_data[w*DATA_W +: DATA_W];
      end
    end
    if (!in_range || is_zero_reg) begin
      value = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with registered reads, write-first
// bypass, deterministic write priority and an out-of-range write flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W     = RF_DATA_W_DEFAULT,
  parameter int DEPTH      = RF_DEPTH_DEFAULT,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1,
  parameter int ZERO_R0    = 1,
  parameter int INIT_INDEX = 1,
  localparam int ADDR_W    = rf_clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_err
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] arr_val [NUM_RD];
  logic [DATA_W-1:0] byp_val [NUM_RD];
  logic              oob_write;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_LIM);
  endfunction

  function automatic logic [DATA_W-1:0] reset_word(input int idx);
    if ((INIT_INDEX == 0) || ((ZERO_R0 != 0) && (idx == 0))) begin
      return '0;
    end
    return DATA_W'(idx);
  endfunction

  always_comb begin
    oob_write = 1'b0;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wr_en[w] && !in_range(wr_addr[w*ADDR_W +: ADDR_W])) begin
        oob_write = 1'b1;
      end
    end
  end

  // Non-blocking writes in port order: the last (highest) port to hit an address wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= reset_word(i);
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w] && in_range(wr_addr[w*ADDR_W +: ADDR_W]) &&
            !((ZERO_R0 != 0) && (wr_addr[w*ADDR_W +: ADDR_W] == '0))) begin
          mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign arr_val[p] = in_range(rd_addr[p*ADDR_W +: ADDR_W]) ?
                        mem[rd_addr[p*ADDR_W +: ADDR_W]] : '0;

    regfile_bypass_mux #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .NUM_WR  (NUM_WR),
      .ZERO_R0 (ZERO_R0),
      .ADDR_W  (ADDR_W)
    ) u_bypass (
      .rd_addr  (rd_addr[p*ADDR_W +: ADDR_W]),
      .arr_data (arr_val[p]),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .value    (byp_val[p])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= byp_val[p];
        end
      end
      wr_err <= oob_write;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Drives two register-file variants (24-deep with zero reg, 32-deep without)
// from shared inputs and checks both against an array-based reference model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      rd_en;
  logic [2*AW-1:0] rd_addr;
  logic [1:0]      wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*DW-1:0] wr_data;
  logic [2*DW-1:0] rd_data_a;
  logic [2*DW-1:0] rd_data_b;
  logic            wr_err_a;
  logic            wr_err_b;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mdl     [2][32];
  logic [31:0] exp_rd  [2][2];
  logic        exp_err [2];
  int          depth_of [2] = '{24, 32};
  bit          zero_of  [2] = '{1'b1, 1'b0};
  bit          init_of  [2] = '{1'b1, 1'b0};

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_W (DW), .DEPTH (24), .NUM_RD (2), .NUM_WR (2), .ZERO_R0 (1), .INIT_INDEX (1)
  ) dut_a (
    .clk (clk), .rst (rst), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_a),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_err (wr_err_a)
  );

  regfile_mp #(
    .DATA_W (DW), .DEPTH (32), .NUM_RD (2), .NUM_WR (2), .ZERO_R0 (0), .INIT_INDEX (0)
  ) dut_b (
    .clk (clk), .rst (rst), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data_b),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_err (wr_err_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    assert (act === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 32; i++) begin
        mdl[k][i] = (init_of[k] && !(zero_of[k] && i == 0)) ? 32'(i) : 32'h0;
      end
      exp_rd[k][0] = 32'h0;
      exp_rd[k][1] = 32'h0;
      exp_err[k]   = 1'b0;
    end
  endtask

  // Apply the edge's writes in port order, then serve reads from the updated array.
  task automatic model_edge();
    int wa;
    int ra;
    for (int k = 0; k < 2; k++) begin
      exp_err[k] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        wa = int'(wr_addr[w*AW +: AW]);
        if (wr_en[w]) begin
          if (wa >= depth_of[k]) exp_err[k] = 1'b1;
          else if (!(zero_of[k] && wa == 0)) mdl[k][wa] = wr_data[w*DW +: DW];
        end
      end
      for (int p = 0; p < 2; p++) begin
        ra = int'(rd_addr[p*AW +: AW]);
        if (rd_en[p]) begin
          exp_rd[k][p] = (ra >= depth_of[k] || (zero_of[k] && ra == 0)) ? 32'h0 : mdl[k][ra];
        end
      end
    end
  endtask

  task automatic check_output();
    for (int p = 0; p < 2; p++) begin
      check($sformatf("rd_data%0d_a", p), rd_data_a[p*DW +: DW], exp_rd[0][p]);
      check($sformatf("rd_data%0d_b", p), rd_data_b[p*DW +: DW], exp_rd[1][p]);
    end
    check("wr_err_a", {31'h0, wr_err_a}, {31'h0, exp_err[0]});
    check("wr_err_b", {31'h0, wr_err_b}, {31'h0, exp_err[1]});
  endtask

  task automatic apply_stimulus(input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                                input logic [31:0] wd0, input logic [31:0] wd1);
    rd_en   = re;
    rd_addr = {ra1, ra0};
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  initial begin
    logic [1:0]  re;
    logic [1:0]  we;
    logic [4:0]  ra0, ra1, wa0, wa1;
    logic [31:0] wd0, wd1;

    rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output();
    @(negedge clk);
    rst = 1'b0;

    // Reset image: reg 5 holds 5 on the indexed variant, reg 0 reads 0
    apply_stimulus(2'b11, 5'd5, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("init_r5_a", rd_data_a[31:0], 32'd5);
    check("init_r0_a", rd_data_a[63:32], 32'd0);

    // Same-cycle bypass, then a later plain read
    apply_stimulus(2'b01, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0, 32'hDEADBEEF, 32'h0);
    check("bypass_a", rd_data_a[31:0], 32'hDEADBEEF);
    apply_stimulus(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    apply_stimulus(2'b01, 5'd7, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("reread7_b", rd_data_b[31:0], 32'hDEADBEEF);

    // Two ports to the same address: port 1 wins
    apply_stimulus(2'b10, 5'd0, 5'd3, 2'b11, 5'd3, 5'd3, 32'h11, 32'h22);
    check("prio_bypass_a", rd_data_a[63:32], 32'h22);
    apply_stimulus(2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("prio_a", rd_data_a[31:0], 32'h22);

    // Register 0 writes: dropped on the zero-reg variant only
    apply_stimulus(2'b01, 5'd0, 5'd0, 2'b01, 5'd0, 5'd0, 32'h55, 32'h0);
    check("r0_bypass_a", rd_data_a[31:0], 32'h0);
    check("r0_bypass_b", rd_data_b[31:0], 32'h55);
    apply_stimulus(2'b01, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("r0_a", rd_data_a[31:0], 32'h0);
    check("r0_b", rd_data_b[31:0], 32'h55);

    // Address 30 is out of range for the 24-deep variant only
    apply_stimulus(2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 5'd30, 32'h0, 32'hAA);
    check("oob_err_a", {31'h0, wr_err_a}, 32'd1);
    apply_stimulus(2'b01, 5'd30, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("oob_err_clear_a", {31'h0, wr_err_a}, 32'd0);
    check("oob_read_a", rd_data_a[31:0], 32'h0);
    check("oob_read_b", rd_data_b[31:0], 32'hAA);

    // Disabled read port holds while its address moves
    apply_stimulus(2'b10, 5'd0, 5'd4, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    apply_stimulus(2'b00, 5'd0, 5'd9, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("hold_a", rd_data_a[63:32], 32'd4);

    // Reset lands on an edge that carries a write to reg 9
    rd_en = 2'b11; rd_addr = {5'd9, 5'd9};
    wr_en = 2'b01; wr_addr = {5'd0, 5'd9}; wr_data = {32'h0, 32'h12345678};
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_output();
    @(negedge clk);
    wr_en = '0; rd_en = '0;
    rst = 1'b0;
    apply_stimulus(2'b01, 5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    check("post_reset_r9_a", rd_data_a[31:0], 32'd9);
    check("post_reset_r9_b", rd_data_b[31:0], 32'd0);

    // Random traffic with deliberate address collisions
    for (int i = 0; i < 400; i++) begin
      re  = 2'($urandom);
      we  = 2'($urandom);
      wa0 = 5'($urandom_range(0, 31));
      wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 2) == 0) ? wa0 : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? wa1 : 5'($urandom_range(0, 31));
      wd0 = $urandom;
      wd1 = $urandom;
      apply_stimulus(re, ra0, ra1, we, wa0, wa1, wd0, wd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
